// File: rtl/il1_pkg.sv
// Shared definitions for the L1 instruction cache: line geometry, FSM states
// and address-field width helpers.
package il1_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BYTES     = 16;
  localparam int OFFSET_LSB     = 2;
  localparam int INDEX_LSB      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } il1State_t;

  // Index width for a direct-mapped array of 'lines' entries.
  function automatic int idxWidth(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above the index field of a 32-bit byte address.
  function automatic int tagWidth(input int lines);
    return 32 - INDEX_LSB - $clog2(lines);
  endfunction

endpackage

// File: rtl/il1_tag_array.sv
// Tag and valid storage for the instruction cache. Combinational lookup port,
// one write port (sets valid), and an invalidate-all that beats the write.
module il1_tag_array #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookupIdx,
  input  logic [TAG_W-1:0] lookupTag,
  output logic             lookupHit,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [TAG_W-1:0] wrTag,
  input  logic             invAll
);

  logic [LINES-1:0]            validQ;
  logic [LINES-1:0][TAG_W-1:0] tagQ;

  assign lookupHit = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);

  // Valid bits: reset/invalidate clear everything; invalidate wins over a fill.
  always_ff @(posedge clk) begin
    if (rst || invAll) validQ <= '0;
    else if (wrEn)     validQ[wrIdx] <= 1'b1;
  end

  // Tags are never reset; a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (wrEn) tagQ[wrIdx] <= wrTag;
  end

endmodule

// File: rtl/il1_cache.sv
// Direct-mapped blocking L1 instruction cache, 4-word lines, word-serial refill.
// Optional hit/miss counters are built when IL1_CACHE_STATS_EN is defined.
module il1_cache
  import il1_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        core2il1_val,
  input  logic [31:0] core2il1_addr,
  input  logic        core2il1_inv,
  output logic        il12core_ack,
  output logic [31:0] il12core_rdata,
  output logic        il12mem_val,
  output logic [31:0] il12mem_addr,
  input  logic        mem2il1_ack,
  input  logic [31:0] mem2il1_rdata
`ifdef IL1_CACHE_STATS_EN
  ,
  output logic [31:0] il1_hit_cnt,
  output logic [31:0] il1_miss_cnt
`endif
);

  localparam int IDX_W = idxWidth(LINES);
  localparam int TAG_W = tagWidth(LINES);

  il1State_t   state, nextState;
  logic [31:2] reqAddr;
  logic [1:0]  beat;
  logic        invPending;
  logic        tagHit;
  logic        tagWr;

  logic [LINES-1:0][WORDS_PER_LINE-1:0][31:0] dataArr;

  logic [1:0]       reqOff;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;
  logic [31:0]      reqWord;

  // Byte-lane bits of the fetch address carry no information for word fetches.
  logic unusedAddrBits;
  assign unusedAddrBits = &{1'b0, core2il1_addr[1:0]};

  assign reqOff  = reqAddr[3:2];
  assign reqIdx  = reqAddr[INDEX_LSB+IDX_W-1:INDEX_LSB];
  assign reqTag  = reqAddr[31:INDEX_LSB+IDX_W];
  assign reqWord = dataArr[reqIdx][reqOff];

  il1_tag_array #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) uTags (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .lookupIdx(reqIdx),
    .lookupTag(reqTag),
    .lookupHit(tagHit),
    .wrEn     (tagWr),
    .wrIdx    (reqIdx),
    .wrTag    (reqTag),
    .invAll   (core2il1_inv)
  );

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= nextState;
  end

  // Next state and all handshake outputs; outputs read zero outside their states.
  always_comb begin
    nextState      = state;
    il12core_ack   = 1'b0;
    il12core_rdata = '0;
    il12mem_val    = 1'b0;
    il12mem_addr   = '0;
    tagWr          = 1'b0;
    case (state)
      IDLE: begin
        if (core2il1_val) nextState = LOOKUP;
      end
      LOOKUP: begin
        if (tagHit) begin
          il12core_ack   = 1'b1;
          il12core_rdata = reqWord;
          nextState      = IDLE;
        end else begin
          nextState = REFILL;
        end
      end
      REFILL: begin
        il12mem_val  = 1'b1;
        il12mem_addr = {reqAddr[31:4], beat, 2'b00};
        if (mem2il1_ack && (beat == 2'd3)) nextState = RESP;
      end
      RESP: begin
        il12core_ack   = 1'b1;
        il12core_rdata = reqWord;
        tagWr          = !invPending;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Capture the fetch address on acceptance; held for the whole transaction.
  always_ff @(posedge sys_clk) begin
    if (state == IDLE && core2il1_val) reqAddr <= core2il1_addr[31:2];
  end

  // Refill beat counter: restarts on each miss, advances on every memory ack.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                                beat <= '0;
    else if (state == LOOKUP && !tagHit)        beat <= '0;
    else if (state == REFILL && mem2il1_ack)    beat <= beat + 2'd1;
  end

  // Remembers an invalidate seen while a fetch is in flight so its refill is not validated.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                             invPending <= 1'b0;
    else if (state == IDLE && core2il1_val)  invPending <= 1'b0;
    else if (core2il1_inv)                   invPending <= 1'b1;
  end

  // Data array fill, one word per memory ack; not reset.
  always_ff @(posedge sys_clk) begin
    if (state == REFILL && mem2il1_ack) dataArr[reqIdx][beat] <= mem2il1_rdata;
  end

`ifdef IL1_CACHE_STATS_EN
  // Lookup outcome counters, free-running with natural wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      il1_hit_cnt  <= '0;
      il1_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (tagHit) il1_hit_cnt  <= il1_hit_cnt + 32'd1;
      else        il1_miss_cnt <= il1_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_il1_cache.sv
// Bench for il1_cache: table of fetches with a core-side scoreboard, a
// memory responder with configurable wait states, and hand-written sequences
// for invalidate, reset-mid-refill and stretched memory acks.
module tb_il1_cache;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        core2il1_val;
  logic [31:0] core2il1_addr;
  logic        core2il1_inv;
  logic        il12core_ack;
  logic [31:0] il12core_rdata;
  logic        il12mem_val;
  logic [31:0] il12mem_addr;
  logic        mem2il1_ack;
  logic [31:0] mem2il1_rdata;
`ifdef IL1_CACHE_STATS_EN
  logic [31:0] il1_hit_cnt;
  logic [31:0] il1_miss_cnt;
`endif

  il1_cache #(.LINES(64)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .core2il1_val  (core2il1_val),
    .core2il1_addr (core2il1_addr),
    .core2il1_inv  (core2il1_inv),
    .il12core_ack  (il12core_ack),
    .il12core_rdata(il12core_rdata),
    .il12mem_val   (il12mem_val),
    .il12mem_addr  (il12mem_addr),
    .mem2il1_ack   (mem2il1_ack),
    .mem2il1_rdata (mem2il1_rdata)
`ifdef IL1_CACHE_STATS_EN
    ,
    .il1_hit_cnt   (il1_hit_cnt),
    .il1_miss_cnt  (il1_miss_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] sb[$];
  logic [31:0] memLog[$];
  int          memDelay = 0;
  int          waitCnt  = 0;
  logic [31:0] heldAddr;
  bit          strayAck = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
  } vec_t;

  vec_t vecs[8];

  // Memory image: word at byte address a; 0x100..0x10C give 0xA0..0xA3.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core-side scoreboard: every ack must match the oldest expected word.
  always @(negedge sys_clk) begin
    if (!sys_rst && il12core_ack) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpected_core_ack: rdata %h with nothing outstanding", il12core_rdata);
      end else begin
        check("core_rdata", il12core_rdata, sb.pop_front());
      end
    end
  end

  // Memory responder: acks after memDelay wait cycles, checks the request is held.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      mem2il1_ack = 1'b0;
      waitCnt     = 0;
    end else if (mem2il1_ack) begin
      mem2il1_ack = 1'b0;
      waitCnt     = 0;
    end else if (strayAck) begin
      mem2il1_ack   = 1'b1;
      mem2il1_rdata = 32'hDEAD_BEEF;
      strayAck      = 0;
    end else if (il12mem_val) begin
      if (waitCnt == 0) heldAddr = il12mem_addr;
      else              check("mem_addr_stable", il12mem_addr, heldAddr);
      if (waitCnt >= memDelay) begin
        mem2il1_ack   = 1'b1;
        mem2il1_rdata = memWord(il12mem_addr);
        memLog.push_back(il12mem_addr);
      end else begin
        waitCnt++;
      end
    end else if (waitCnt > 0) begin
      check("mem_val_held", {31'd0, il12mem_val}, 32'd1);
      waitCnt = 0;
    end
  end

  // One fetch: pushes the expected word, waits for ack, checks latency and refill traffic.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit expMiss);
    int lat;
    int base;
    bit got;
    base = memLog.size();
    sb.push_back(exp);
    @(negedge sys_clk);
    core2il1_val  = 1'b1;
    core2il1_addr = a;
    lat = 0;
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (il12core_ack) got = 1;
    end
    core2il1_val = 1'b0;
    if (!got) begin
      nChecks++;
      nFail++;
      $display("FAIL fetch_timeout: addr %h got no ack, required ack", a);
      sb.delete();
      return;
    end
    if (!expMiss) check("hit_latency", lat, 32'd1);
    check("mem_reads", memLog.size() - base, expMiss ? 32'd4 : 32'd0);
    if (expMiss && memLog.size() - base == 4)
      for (int i = 0; i < 4; i++)
        check("refill_addr", memLog[base+i], {a[31:4], 4'h0} + 32'(4 * i));
  endtask

  task automatic doReset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    core2il1_val = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    int base;
    vecs[0] = '{32'h100, 32'hA0,  1'b1};
    vecs[1] = '{32'h104, 32'hA1,  1'b0};
    vecs[2] = '{32'h10C, 32'hA3,  1'b0};
    vecs[3] = '{32'h500, 32'h1A0, 1'b1};
    vecs[4] = '{32'h100, 32'hA0,  1'b1};
    vecs[5] = '{32'h200, 32'hE0,  1'b1};
    vecs[6] = '{32'h208, 32'hE2,  1'b0};
    vecs[7] = '{32'h108, 32'hA2,  1'b0};

    sys_rst = 1'b1;
    core2il1_val = 1'b0;
    core2il1_addr = '0;
    core2il1_inv = 1'b0;
    mem2il1_ack = 1'b0;
    mem2il1_rdata = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_core_ack", {31'd0, il12core_ack}, 32'd0);
    check("rst_core_rdata", il12core_rdata, 32'd0);
    check("rst_mem_val", {31'd0, il12mem_val}, 32'd0);
    check("rst_mem_addr", il12mem_addr, 32'd0);
    sys_rst = 1'b0;

    // Table: cold miss, hits in the line, conflict eviction, second index.
    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].data, vecs[i].miss);
`ifdef IL1_CACHE_STATS_EN
      if (i == 1) begin
        check("hit_cnt", il1_hit_cnt, 32'd1);
        check("miss_cnt", il1_miss_cnt, 32'd1);
      end
`endif
    end

    // Invalidate between fetches forces a refill.
    fetch(32'h100, 32'hA0, 1'b0);
    @(negedge sys_clk);
    core2il1_inv = 1'b1;
    @(negedge sys_clk);
    core2il1_inv = 1'b0;
    fetch(32'h100, 32'hA0, 1'b1);

    // Invalidate during a lookup hit: stale word returned, line gone afterwards.
    fork
      fetch(32'h104, 32'hA1, 1'b0);
      begin
        @(negedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        core2il1_inv = 1'b1;
        @(negedge sys_clk);
        core2il1_inv = 1'b0;
      end
    join
    fetch(32'h100, 32'hA0, 1'b1);

    // Invalidate mid-refill: data still returned, line not validated.
    fork
      fetch(32'h200, 32'hE0, 1'b1);
      begin
        base = memLog.size();
        for (int c = 0; c < 300 && memLog.size() < base + 2; c++) @(negedge sys_clk);
        @(negedge sys_clk);
        core2il1_inv = 1'b1;
        @(negedge sys_clk);
        core2il1_inv = 1'b0;
      end
    join
    fetch(32'h204, 32'hE1, 1'b1);
    fetch(32'h20C, 32'hE3, 1'b0);

    // Reset during refill beat 2, then a stray memory ack.
    memDelay = 3;
    base = memLog.size();
    @(negedge sys_clk);
    core2il1_val  = 1'b1;
    core2il1_addr = 32'h100;
    for (int c = 0; c < 300 && memLog.size() < base + 2; c++) @(negedge sys_clk);
    check("refill_progress", memLog.size() - base, 32'd2);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    core2il1_val = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_mid_mem_val", {31'd0, il12mem_val}, 32'd0);
    check("rst_mid_core_ack", {31'd0, il12core_ack}, 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    strayAck = 1;
    repeat (4) @(negedge sys_clk);
    check("stray_mem_val", {31'd0, il12mem_val}, 32'd0);
    check("stray_no_reads", memLog.size() - base, 32'd2);
    fetch(32'h104, 32'hA1, 1'b1);

    // Stretched memory acks: request must stay stable through the waits.
    memDelay = 5;
    fetch(32'h300, 32'h120, 1'b1);
    fetch(32'h304, 32'h121, 1'b0);
    memDelay = 0;

    doReset();
`ifdef IL1_CACHE_STATS_EN
    check("hit_cnt_rst", il1_hit_cnt, 32'd0);
    check("miss_cnt_rst", il1_miss_cnt, 32'd0);
`endif
    fetch(32'h300, 32'h120, 1'b1);

    repeat (3) @(negedge sys_clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
